// File: rtl/mmss_countdown.sv
// rtl/mmss_countdown.sv - MM:SS count-down timer FSM feeding a four-digit seven-segment driver
module mmss_countdown #(
   parameter int unsigned EXPIRE_SECS = 10
) (
   input  logic       f_clk,
   input  logic       rst_n,
   input  logic       tick,
   input  logic       btn_start,
   input  logic       btn_clear,
   input  logic       btn_min_inc,
   input  logic       btn_sec_inc,
   output logic [3:0] seg1,
   output logic [3:0] seg2,
   output logic [3:0] seg3,
   output logic [3:0] seg4,
   output logic [1:0] mode,
   output logic       done
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_RUN     = 2'd1,
      S_PAUSE   = 2'd2,
      S_EXPIRED = 2'd3
   } state_t;

   localparam logic [1:0] MODE_ON    = 2'd1;
   localparam logic [1:0] MODE_BLINK = 2'd2;
   localparam logic [1:0] MODE_FAST  = 2'd3;
   localparam logic [7:0] EXP_LIMIT  = 8'(EXPIRE_SECS);

   state_t      state;
   logic [15:0] preset;
   logic [7:0]  exp_cnt;
   logic [3:0]  dec_s1, dec_s2, dec_s3, dec_s4;
   logic        last_sec;
   logic        time_zero;

   // Two-digit BCD increment over 00..59, wrapping to 00 with no carry out.
   function automatic logic [7:0] inc59(input logic [7:0] v);
      logic [7:0] r;
      if (v[3:0] == 4'd9) begin
         r = (v[7:4] == 4'd5) ? 8'h00 : {v[7:4] + 4'd1, 4'd0};
      end else begin
         r = {v[7:4], v[3:0] + 4'd1};
      end
      return r;
   endfunction

   always_comb begin
      dec_s1 = seg1;
      dec_s2 = seg2;
      dec_s3 = seg3;
      dec_s4 = seg4;
      if (seg1 != 4'd0) begin
         dec_s1 = seg1 - 4'd1;
      end else begin
         dec_s1 = 4'd9;
         if (seg2 != 4'd0) begin
            dec_s2 = seg2 - 4'd1;
         end else begin
            dec_s2 = 4'd5;
            if (seg3 != 4'd0) begin
               dec_s3 = seg3 - 4'd1;
            end else begin
               dec_s3 = 4'd9;
               dec_s4 = (seg4 != 4'd0) ? seg4 - 4'd1 : 4'd5;
            end
         end
      end
   end

   assign last_sec  = ({seg4, seg3, seg2} == 12'h000) && (seg1 == 4'd1);
   assign time_zero = ({seg4, seg3, seg2, seg1} == 16'h0000);

   always_ff @(posedge f_clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= S_IDLE;
         seg1    <= 4'd0;
         seg2    <= 4'd0;
         seg3    <= 4'd0;
         seg4    <= 4'd0;
         preset  <= 16'h0000;
         exp_cnt <= 8'd0;
         mode    <= MODE_ON;
         done    <= 1'b0;
      end else begin
         done <= 1'b0;
         if (btn_clear) begin
            state   <= S_IDLE;
            {seg4, seg3, seg2, seg1} <= 16'h0000;
            preset  <= 16'h0000;
            exp_cnt <= 8'd0;
            mode    <= MODE_ON;
         end else begin
            case (state)
               S_IDLE: begin
                  if (btn_start && !time_zero) begin
                     preset <= {seg4, seg3, seg2, seg1};
                     state  <= S_RUN;
                     mode   <= MODE_ON;
                  end else if (!btn_start) begin
                     if (btn_min_inc) {seg4, seg3} <= inc59({seg4, seg3});
                     if (btn_sec_inc) {seg2, seg1} <= inc59({seg2, seg1});
                  end
               end
               S_RUN: begin
                  if (btn_start) begin
                     state <= S_PAUSE;
                     mode  <= MODE_BLINK;
                  end else if (tick) begin
                     {seg4, seg3, seg2, seg1} <= {dec_s4, dec_s3, dec_s2, dec_s1};
                     // Reaching zero expires on the same edge as the final decrement.
                     if (last_sec) begin
                        state   <= S_EXPIRED;
                        mode    <= MODE_FAST;
                        exp_cnt <= 8'd0;
                        done    <= 1'b1;
                     end
                  end
               end
               S_PAUSE: begin
                  if (btn_start) begin
                     state <= S_RUN;
                     mode  <= MODE_ON;
                  end
               end
               S_EXPIRED: begin
                  if (btn_start || (tick && (exp_cnt + 8'd1 == EXP_LIMIT))) begin
                     {seg4, seg3, seg2, seg1} <= preset;
                     state <= S_IDLE;
                     mode  <= MODE_ON;
                  end else if (tick) begin
                     exp_cnt <= exp_cnt + 8'd1;
                  end
               end
               default: begin
                  state <= S_IDLE;
                  mode  <= MODE_ON;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_mmss_countdown.sv
// tb/tb_mmss_countdown.sv - scoreboard bench for mmss_countdown
module tb_mmss_countdown;

   logic       f_clk = 1'b0;
   logic       rst_n;
   logic       tick = 1'b0, btn_start = 1'b0, btn_clear = 1'b0;
   logic       btn_min_inc = 1'b0, btn_sec_inc = 1'b0;
   logic [3:0] seg1, seg2, seg3, seg4;
   logic [1:0] mode;
   logic       done;

   mmss_countdown #(.EXPIRE_SECS(3)) dut (
      .f_clk(f_clk), .rst_n(rst_n), .tick(tick), .btn_start(btn_start),
      .btn_clear(btn_clear), .btn_min_inc(btn_min_inc), .btn_sec_inc(btn_sec_inc),
      .seg1(seg1), .seg2(seg2), .seg3(seg3), .seg4(seg4), .mode(mode), .done(done)
   );

   always #5 f_clk = ~f_clk;

   typedef struct {
      int unsigned      cyc;
      logic [15:0]      t;
      logic [1:0]       md;
      logic             dn;
      logic [8*16-1:0]  name;
   } exp_t;

   exp_t        sb[$];
   exp_t        e;
   int unsigned cyc = 0;
   int          checks = 0;
   int          errors = 0;
   int          done_cnt = 0;

   always @(posedge f_clk) cyc <= cyc + 1;

   // Monitor: compares every queued expectation due at or before this cycle.
   always @(negedge f_clk) begin
      if (done === 1'b1) done_cnt = done_cnt + 1;
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
         e = sb.pop_front();
         checks = checks + 1;
         if ({seg4, seg3, seg2, seg1} !== e.t || mode !== e.md || done !== e.dn) begin
            errors = errors + 1;
            $display("FAIL %0s: got time %h mode %0d done %0d, required time %h mode %0d done %0d",
                     e.name, {seg4, seg3, seg2, seg1}, mode, done, e.t, e.md, e.dn);
         end
      end
   end

   task automatic step(input logic st, input logic cl, input logic mi, input logic si, input logic tk);
      @(negedge f_clk);
      btn_start = st; btn_clear = cl; btn_min_inc = mi; btn_sec_inc = si; tick = tk;
      @(posedge f_clk);
      #1;
      btn_start = 1'b0; btn_clear = 1'b0; btn_min_inc = 1'b0; btn_sec_inc = 1'b0; tick = 1'b0;
   endtask

   task automatic chk(input logic [8*16-1:0] nm, input logic [15:0] t, input logic [1:0] md, input logic dn);
      exp_t x;
      x.cyc = cyc; x.t = t; x.md = md; x.dn = dn; x.name = nm;
      sb.push_back(x);
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 1);
   endtask

   initial begin
      rst_n = 1'b0;
      #1;
      chk("reset", 16'h0000, 2'd1, 1'b0);
      @(negedge f_clk);
      #1 rst_n = 1'b1;

      // Set time: 3 minute incs, 61 second incs (wraps past 59)
      for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0);
      chk("min_inc3", 16'h0300, 2'd1, 1'b0);
      for (int i = 0; i < 61; i++) step(0, 0, 0, 1, 0);
      chk("sec_inc61", 16'h0301, 2'd1, 1'b0);

      // Run 01:00 down with borrow to expiry
      step(0, 1, 0, 0, 0);
      step(0, 0, 1, 0, 0);
      step(1, 0, 0, 0, 0);
      chk("start_0100", 16'h0100, 2'd1, 1'b0);
      ticks(1);
      chk("borrow_0059", 16'h0059, 2'd1, 1'b0);
      ticks(58);
      chk("run_0001", 16'h0001, 2'd1, 1'b0);
      ticks(1);
      chk("expire_done", 16'h0000, 2'd3, 1'b1);
      step(0, 0, 0, 0, 0);
      chk("done_1cyc", 16'h0000, 2'd3, 1'b0);
      ticks(2);
      chk("exp_hold2", 16'h0000, 2'd3, 1'b0);
      ticks(1);
      chk("exp_return", 16'h0100, 2'd1, 1'b0);

      // Pause and resume at 00:30
      step(0, 1, 0, 0, 0);
      for (int i = 0; i < 30; i++) step(0, 0, 0, 1, 0);
      step(1, 0, 0, 0, 0);
      step(1, 0, 0, 0, 1);
      chk("pause", 16'h0030, 2'd2, 1'b0);
      for (int i = 0; i < 5; i++) begin
         ticks(1);
         chk("pause_frozen", 16'h0030, 2'd2, 1'b0);
      end
      step(1, 0, 0, 0, 0);
      chk("resume", 16'h0030, 2'd1, 1'b0);
      ticks(1);
      chk("resume_tick", 16'h0029, 2'd1, 1'b0);

      // Expiry from 00:02, auto return then start-acknowledge
      step(0, 1, 0, 0, 0);
      step(0, 0, 0, 1, 0);
      step(0, 0, 0, 1, 0);
      step(1, 0, 0, 0, 0);
      ticks(2);
      chk("exp2_done", 16'h0000, 2'd3, 1'b1);
      ticks(3);
      chk("exp2_auto", 16'h0002, 2'd1, 1'b0);
      step(1, 0, 0, 0, 0);
      ticks(2);
      chk("exp3_done", 16'h0000, 2'd3, 1'b1);
      step(1, 0, 0, 0, 0);
      chk("exp3_ack", 16'h0002, 2'd1, 1'b0);

      // Priority and clear
      step(1, 0, 0, 0, 0);
      step(1, 1, 1, 0, 1);
      chk("clear_prio", 16'h0000, 2'd1, 1'b0);
      step(1, 0, 0, 0, 0);
      ticks(1);
      chk("start_zero", 16'h0000, 2'd1, 1'b0);
      step(0, 0, 1, 0, 0);
      step(1, 0, 0, 0, 0);
      step(0, 0, 1, 0, 0);
      chk("inc_in_run", 16'h0100, 2'd1, 1'b0);
      ticks(1);
      chk("run_after_inc", 16'h0059, 2'd1, 1'b0);

      // Minute wrap, dual inc, borrow from tens of minutes
      step(0, 1, 0, 0, 0);
      for (int i = 0; i < 59; i++) step(0, 0, 1, 0, 0);
      chk("min_59", 16'h5900, 2'd1, 1'b0);
      step(0, 0, 1, 0, 0);
      chk("min_wrap", 16'h0000, 2'd1, 1'b0);
      step(0, 0, 1, 1, 0);
      chk("dual_inc", 16'h0101, 2'd1, 1'b0);
      step(0, 1, 0, 0, 0);
      for (int i = 0; i < 10; i++) step(0, 0, 1, 0, 0);
      step(1, 0, 0, 0, 0);
      ticks(1);
      chk("borrow_0959", 16'h0959, 2'd1, 1'b0);

      // Async reset mid-run at 12:34
      step(0, 1, 0, 0, 0);
      for (int i = 0; i < 12; i++) step(0, 0, 1, 0, 0);
      for (int i = 0; i < 34; i++) step(0, 0, 0, 1, 0);
      step(1, 0, 0, 0, 0);
      chk("run_1234", 16'h1234, 2'd1, 1'b0);
      @(posedge f_clk);
      #2 rst_n = 1'b0;
      chk("async_reset", 16'h0000, 2'd1, 1'b0);
      @(negedge f_clk);
      #1 rst_n = 1'b1;
      ticks(1);
      chk("post_reset", 16'h0000, 2'd1, 1'b0);

      for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge f_clk);
      @(negedge f_clk);
      #1;
      checks = checks + 1;
      if (sb.size() != 0) begin
         errors = errors + 1;
         $display("FAIL drain: got %0d pending, required 0", sb.size());
      end
      checks = checks + 1;
      if (done_cnt != 3) begin
         errors = errors + 1;
         $display("FAIL done_count: got %0d, required 3", done_cnt);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mmss_countdown.md
# mmss_countdown

Count-down timer that produces the four BCD digits (MM:SS) and the display mode for the four-digit seven-segment display driver, which sits directly downstream. Single-cycle pulses for buttons and a 1 Hz tick, all synchronous to the fast clock, drive a four-state FSM. The FSM sets, runs, pauses and expires the timer. Digit and mode outputs are registered and connect directly to that driver's `seg1..seg4` and `mode` inputs.

## Interface
- `EXPIRE_SECS`, default 10: number of ticks spent in EXPIRED before auto-return to IDLE; legal range 1..255.
- `f_clk` in 1: the only clock; all logic is on its rising edge.
- `rst_n` in 1: reset, asynchronous and active-low. Assert asynchronously; release synchronously to `f_clk` upstream.
- `tick` in 1: one-`f_clk`-cycle pulse at 1 Hz.
- `btn_start` in 1: one-cycle pulse. Start/pause/resume/acknowledge.
- `btn_clear` in 1: one-cycle pulse. Clear time and preset.
- `btn_min_inc` in 1: one-cycle pulse. Increment minutes; honoured in IDLE only.
- `btn_sec_inc` in 1: one-cycle pulse. Increment seconds; honoured in IDLE only.
- `seg1` out 4: seconds ones, BCD 0–9 (rightmost digit).
- `seg2` out 4: seconds tens, BCD 0–5.
- `seg3` out 4: minutes ones, BCD 0–9.
- `seg4` out 4: minutes tens, BCD 0–5.
- `mode` out 2: display mode. 0 = off, 1 = on, 2 = 0.5 Hz blink, 3 = 1 Hz blink.
- `done` out 1: one-cycle pulse on entry to EXPIRED.

## Operation
- Storage:
  - Current time: four BCD digits.
  - Preset: four BCD digits, captured at start.
  - Expiry counter: 8 bits.
- Input priority within one cycle: `btn_clear` > `btn_start` > `btn_min_inc`/`btn_sec_inc` > `tick`. A tick arriving in the same cycle as any honoured button is discarded.
- IDLE state (`mode` = 1):
  - `btn_min_inc`: minutes +1 in BCD, 59 → 00. Seconds are unaffected.
  - `btn_sec_inc`: seconds +1 in BCD, 59 → 00, with no carry into minutes.
  - If both inc pulses arrive together, both are applied.
  - `btn_start` with time ≠ 00:00: copy time into preset, go to RUN.
  - `btn_start` with time = 00:00: ignored, stay in IDLE.
- RUN state (`mode` = 1):
  - On `tick`, decrement time by one second in BCD:
    - `seg1` 0 → 9 borrows from `seg2`;
    - `seg2` 0 → 5 borrows from `seg3`;
    - `seg3` 0 → 9 borrows from `seg4`.
  - A decrement that reaches 00:00 moves the FSM to EXPIRED in the same edge and pulses `done`.
  - `btn_start`: go to PAUSE.
  - Inc buttons are ignored.
- PAUSE state (`mode` = 2):
  - Time is frozen; ticks are ignored.
  - `btn_start`: go to RUN. Counting resumes on the next tick after the resume cycle. A partial first second is accepted.
- EXPIRED state (`mode` = 3):
  - Time shows 00:00. The expiry counter loads 0 on entry and increments per tick.
  - When the counter reaches `EXPIRE_SECS`: time ← preset, go to IDLE.
  - `btn_start`: time ← preset, go to IDLE immediately.
- `btn_clear`, in any state: time ← 00:00, preset ← 00:00, expiry counter ← 0, go to IDLE.

## Timing
- Reset values:
  - state IDLE;
  - `seg1..seg4` = 0;
  - preset = 00:00;
  - expiry counter = 0;
  - `mode` = 1;
  - `done` = 0.
- Latency: every input pulse sampled at edge N is reflected on `seg*`/`mode`/`done` after edge N (one-cycle registered latency). No combinational path from inputs to outputs.
- `done` is high for exactly one `f_clk` cycle per expiry, coincident with the first cycle `mode` = 3.
- Digits never leave legal BCD ranges, including across wrap, borrow and reset.
- Reset asserted mid-RUN or mid-EXPIRED: outputs go to reset values asynchronously. No `done` pulse is produced.
- The downstream driver samples `seg*`/`mode` freely; outputs change at most once per `f_clk` edge and glitch-free.

## Test plan
- Reset, then set time:
  - Stimulus: release `rst_n`; 3× `btn_min_inc`; 61× `btn_sec_inc`.
  - Required: `seg4..seg1` = 0,3,0,1; `mode` = 1.
- Run with borrow:
  - Stimulus: preset 01:00; `btn_start`; 1 tick.
  - Required: 00:59, `mode` = 1.
  - Stimulus: 59 more ticks.
  - Required: 00:00, `mode` = 3, `done` high exactly 1 cycle.
- Pause and resume:
  - Stimulus: at 00:30 in RUN, `btn_start` and `tick` in the same cycle.
  - Required: `mode` = 2, time stays 00:30.
  - Stimulus: 5 ticks, then `btn_start`, then 1 tick.
  - Required: time stays 00:30 through the 5 ticks; 00:29 after the final tick, `mode` = 1.
- Expiry return:
  - Stimulus: with `EXPIRE_SECS` = 3, expire from preset 00:02; then 3 ticks.
  - Required: IDLE with 00:02, `mode` = 1.
  - Stimulus: repeat the expiry; `btn_start` during EXPIRED.
  - Required: immediate IDLE, 00:02.
- Priority and clear:
  - Stimulus: `btn_clear` + `btn_start` + `btn_min_inc` in the same cycle while in RUN.
  - Required: IDLE, 00:00.
  - Stimulus: `btn_start` at 00:00.
  - Required: stays IDLE.
  - Stimulus: `btn_min_inc` in RUN.
  - Required: ignored.
- Async reset:
  - Stimulus: drop `rst_n` between clock edges during RUN at 12:34.
  - Required: outputs read 00:00, `mode` = 1, `done` = 0 before the next edge.
